uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Parametrised serial transmitter; successor to the fixed 8N1 DIP-switch sender.
//  Accepts words over a valid/ready handshake into a 1-entry holding buffer.
//  Serialises each word as start, data (LSB first), optional parity and 1|2 stop bits on TX_OUT.
//  Sits between board-level producers (switches, FIFOs) and the RX pin of a receiver board.
// PARAMETERS
//  CLK_DIV    5208  M_CLOCK cycles per bit (9600 baud @ 50 MHz); legal range >= 2
//  DATA_BITS  8     data bits per frame; legal range 5..9
//  PARITY     0     0 = none, 1 = odd, 2 = even
//  STOP_BITS  1     1 or 2
//  Illegal values cause an elaboration-time $error.
// PORTS
//  M_CLOCK    in   1          system clock, all logic on posedge
//  M_RESET_N  in   1          asynchronous, active-low reset
//  TX_DATA    in   DATA_BITS  word to send; sampled only on accept
//  TX_VALID   in   1          producer has a word
//  TX_READY   out  1          holding buffer empty; accept = TX_VALID & TX_READY at posedge
//  TX_OUT     out  1          serial line, idles high
//  TX_BUSY    out  1          shifter mid-frame (start through last stop bit)
// BEHAVIOUR
//  Reset (async assert, sync release): TX_OUT=1, TX_READY=1, TX_BUSY=0, state IDLE.
//    Reset also clears the buffer, bit timer and bit counter.
//    Reset mid-frame aborts the frame. Line returns high immediately. The aborted word is not resent.
//  Buffer: on accept at edge N, TX_DATA is latched and TX_READY=0 from N.
//    TX_DATA changes after accept have no effect.
//  Shifter load: occurs when the buffer is full and the shifter is IDLE, or at the end of the last stop bit.
//    The load empties the buffer, so TX_READY=1 again.
//    From IDLE, an accept at edge N loads at N+1: TX_OUT=0 and TX_BUSY=1 from N+1.
//    Back-to-back: the next start bit follows the last stop bit with zero idle cycles.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START if buffer full, else IDLE).
//    PARITY is skipped when PARITY=0. STOP repeats STOP_BITS times.
//  Every bit lasts exactly CLK_DIV cycles. The bit timer runs 0..CLK_DIV-1 and restarts on load.
//    No tick leaks across IDLE.
//  Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
//  Parity is computed from the latched word at load.
//    Even: XOR of the data bits. Odd: the inverted XOR.
//  Bit counter width is $clog2(DATA_BITS+1). Timer width is $clog2(CLK_DIV).
//  TX_OUT is driven from a flop, so the line is glitch-free.
//  TX_VALID while TX_READY=0: no accept; the producer holds the word.
// STRUCTURE
//  Package uart_pkg holds:
//    the state enum (IDLE, START, DATA, PARITY, STOP);
//    parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
//    function frame_bits(DATA_BITS, PARITY, STOP_BITS).
//  Sub-module uart_baud_gen: bit-period counter with restart input and one-cycle bit_end pulse.
//    The RX side reuses it.
//  The top holds the buffer, shifter, FSM and parity flop.
// TESTING (bench uses CLK_DIV=4)
//  1 Reset: M_RESET_N=0 -> TX_OUT=1, TX_READY=1, TX_BUSY=0 without waiting for a clock edge.
//  2 8N1, send 0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
//    TX_BUSY falls after 40 cycles.
//  3 PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0.
//    Both frames are 44 cycles.
//  4 TX_VALID held, 0x55 then 0xAA -> 2nd start bit at cycle 40 exactly; TX_READY re-asserts at each load.
//    Total 80 cycles.
//  5 Reset pulse during data bit 3 of 0xFF -> TX_OUT=1 immediately.
//    After release: idle high, TX_READY=1, no further transitions.
//  6 DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x41 -> 40-cycle frame; the final 8 cycles are high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: FSM states,
// parity selection constants and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Number of bit periods in one serial frame.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while running and pulses o_bit_end
// on the last cycle of each bit. Held at zero when idle or on restart.
module uart_baud_gen #(
    parameter int CLK_DIV = 5208
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    input  logic i_run,
    output logic o_bit_end
);

    localparam int              CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || !i_run || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Not gated by restart: a back-to-back load is itself triggered by this pulse.
    assign o_bit_end = i_run && w_at_last;

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: 1-entry holding buffer behind a valid/ready
// handshake, feeding a shifter that emits start, data, optional parity and stop bits.
module uart_tx_frame #(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 M_CLOCK,
    input  logic                 M_RESET_N,
    input  logic [DATA_BITS-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 TX_OUT,
    output logic                 TX_BUSY
);

    import uart_pkg::*;

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("uart_tx_frame: CLK_DIV must be >= 2 (got %0d)", CLK_DIV);
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9 (got %0d)", DATA_BITS);
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2 (got %0d)", PARITY);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2 (got %0d)", STOP_BITS);
    end

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        if (PARITY == PAR_ODD) begin
            return ~(^d);
        end
        return ^d;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_buf;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_tx_out;
    logic                 r_busy;
    logic                 w_tx_next;
    logic                 w_busy_next;
    logic                 w_bit_end;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_last_data;
    logic                 w_last_stop;

    assign w_accept    = TX_VALID && !r_buf_full;
    assign w_last_data = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));
    assign w_load      = r_buf_full &&
                         ((r_state == S_IDLE) ||
                          ((r_state == S_STOP) && w_bit_end && w_last_stop));

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .i_clk     (M_CLOCK),
        .i_rst_n   (M_RESET_N),
        .i_restart (w_load),
        .i_run     (r_state != S_IDLE),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) w_next_state = S_START;
            end
            S_START: begin
                if (w_bit_end) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && w_last_data) begin
                    w_next_state = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_next_state = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_next_state = r_buf_full ? S_START : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // The line value is decided one cycle ahead so TX_OUT can come straight from a flop.
    always_comb begin
        w_tx_next   = r_tx_out;
        w_busy_next = (w_next_state != S_IDLE);
        unique case (w_next_state)
            S_IDLE:   w_tx_next = 1'b1;
            S_START:  w_tx_next = 1'b0;
            S_DATA: begin
                if (r_state != S_DATA) begin
                    w_tx_next = r_shift[0];
                end else if (w_bit_end) begin
                    w_tx_next = r_shift[1];
                end
            end
            S_PARITY: w_tx_next = r_par;
            S_STOP:   w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_tx_out <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_buf_full <= 1'b0;
            r_buf      <= '0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf      <= TX_DATA;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // The bit counter is shared: data-bit index in DATA, stop-bit index in STOP.
    always_ff @(posedge M_CLOCK or negedge M_RESET_N) begin
        if (!M_RESET_N) begin
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= r_buf;
            r_par     <= calc_parity(r_buf);
            r_bit_cnt <= '0;
        end else if (w_bit_end) begin
            unique case (r_state)
                S_DATA: begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BIT_W'(1);
                end
                S_STOP: begin
                    r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + BIT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign TX_READY = !r_buf_full;
    assign TX_OUT   = r_tx_out;
    assign TX_BUSY  = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) at CLK_DIV=4,
// each line checked cycle by cycle against a frame built from the bit-order rules.
module tb_uart_tx_frame;

    localparam int CLK_DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] v_valid = '0;
    logic [8:0] v_data [4];
    wire  [3:0] w_tx;
    wire  [3:0] w_busy;
    wire  [3:0] w_rdy;

    int db_t [4] = '{8, 8, 8, 7};
    int par_t[4] = '{0, 2, 1, 0};
    int sb_t [4] = '{1, 1, 1, 2};

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n81 (
        .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(v_data[0][7:0]), .TX_VALID(v_valid[0]),
        .TX_READY(w_rdy[0]), .TX_OUT(w_tx[0]), .TX_BUSY(w_busy[0]));
    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e81 (
        .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(v_data[1][7:0]), .TX_VALID(v_valid[1]),
        .TX_READY(w_rdy[1]), .TX_OUT(w_tx[1]), .TX_BUSY(w_busy[1]));
    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_o81 (
        .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(v_data[2][7:0]), .TX_VALID(v_valid[2]),
        .TX_READY(w_rdy[2]), .TX_OUT(w_tx[2]), .TX_BUSY(w_busy[2]));
    uart_tx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_n72 (
        .M_CLOCK(clk), .M_RESET_N(rst_n), .TX_DATA(v_data[3][6:0]), .TX_VALID(v_valid[3]),
        .TX_READY(w_rdy[3]), .TX_OUT(w_tx[3]), .TX_BUSY(w_busy[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b);
        repeat (CLK_DIV) exp_q.push_back(b);
    endtask

    // Expected line, one entry per clock: start, data LSB first, parity, stop bits.
    task automatic build_exp(input int idx, input logic [8:0] d, input bit clear);
        int   ones;
        logic p;
        if (clear) exp_q.delete();
        ones = 0;
        push_bit(1'b0);
        for (int b = 0; b < db_t[idx]; b++) begin
            push_bit(d[b]);
            ones += int'(d[b]);
        end
        if (par_t[idx] != 0) begin
            p = (par_t[idx] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            push_bit(p);
        end
        for (int s = 0; s < sb_t[idx]; s++) push_bit(1'b1);
    endtask

    task automatic check_idle(input int idx, input string tag);
        check_eq({tag, "_tx"},    32'(w_tx[idx]),   32'd1);
        check_eq({tag, "_busy"},  32'(w_busy[idx]), 32'd0);
        check_eq({tag, "_ready"}, 32'(w_rdy[idx]),  32'd1);
    endtask

    // Presents d one cycle after an edge; it is accepted on the next edge.
    task automatic send(input int idx, input logic [8:0] d, input bit b2b, input logic [8:0] d2);
        @(posedge clk); #1;
        v_data[idx]  = d;
        v_valid[idx] = 1'b1;
        @(posedge clk); #1;
        check_eq("accept_ready", 32'(w_rdy[idx]),  32'd0);
        check_eq("accept_tx",    32'(w_tx[idx]),   32'd1);
        check_eq("accept_busy",  32'(w_busy[idx]), 32'd0);
        if (b2b) begin
            v_data[idx] = d2;
        end else begin
            v_valid[idx] = 1'b0;
            v_data[idx]  = ~d;
        end
    endtask

    task automatic run_stream(input int idx, input bit b2b, input int len1, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            check_eq("line", 32'(w_tx[idx]), 32'(exp_q[k]));
            check_eq("busy", 32'(w_busy[idx]), 32'd1);
            if (k == 0) check_eq("load_ready", 32'(w_rdy[idx]), 32'd1);
            if (b2b && k == 1) begin
                check_eq("second_accept_ready", 32'(w_rdy[idx]), 32'd0);
                v_valid[idx] = 1'b0;
            end
            if (b2b && k == len1) check_eq("second_load_ready", 32'(w_rdy[idx]), 32'd1);
        end
        if (ncyc == exp_q.size()) begin
            @(posedge clk); #1;
            check_idle(idx, "frame_end");
        end
    endtask

    task automatic one_frame(input int idx, input logic [8:0] d);
        build_exp(idx, d, 1'b1);
        send(idx, d, 1'b0, 9'd0);
        run_stream(idx, 1'b0, 0, exp_q.size());
    endtask

    task automatic two_frames(input int idx, input logic [8:0] d1, input logic [8:0] d2);
        int len1;
        build_exp(idx, d1, 1'b1);
        len1 = exp_q.size();
        build_exp(idx, d2, 1'b0);
        send(idx, d1, 1'b1, d2);
        run_stream(idx, 1'b1, len1, exp_q.size());
    endtask

    task automatic reset_mid_frame(input logic [8:0] d, input int ncyc);
        build_exp(0, d, 1'b1);
        send(0, d, 1'b0, 9'd0);
        run_stream(0, 1'b0, 0, ncyc);
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "abort");
        @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 5 * CLK_DIV; k++) begin
            @(posedge clk); #1;
            check_idle(0, "after_abort");
        end
    endtask

    initial begin
        logic [8:0] rd;
        logic [8:0] rd2;
        int         idx;
        for (int i = 0; i < 4; i++) v_data[i] = '0;

        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        one_frame(0, 9'h0A5);
        one_frame(1, 9'h007);
        one_frame(2, 9'h007);
        two_frames(0, 9'h055, 9'h0AA);
        one_frame(3, 9'h041);
        reset_mid_frame(9'h0FF, 17);
        reset_mid_frame(9'h000, 10);

        for (int it = 0; it < 12; it++) begin
            idx = $urandom_range(0, 3);
            rd  = 9'($urandom_range(0, 511));
            rd2 = 9'($urandom_range(0, 511));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check_idle(idx, "gap");
            end
            if ($urandom_range(0, 2) == 0) two_frames(idx, rd, rd2);
            else                          one_frame(idx, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
